// File: rtl/j68_ram_port_arbiter.sv
// Port-B arbiter for the J68 microcode/register block RAM: the CPU register path
// has fixed priority; a host debug port is guaranteed service by a short CPU stall.
module j68_ram_port_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int MAX_STALL = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clocken,
    input  logic              cpu_req,
    input  logic [1:0]        cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [1:0]        host_be,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_clocken,
    output logic [1:0]        ram_wren_b,
    output logic [ADDR_W-1:0] ram_address_b,
    output logic [DATA_W-1:0] ram_data_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    // state    | meaning
    // IDLE     | port B may be handed to the host; host-lost cycles are counted
    // CAPTURE  | host access issued last cycle; RAM output carries host data
    // ACK      | host_ack held high until host_req falls

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACK     = 2'd2
    } state_t;

    localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              cpu_stall_q, cpu_stall_d;
    logic              host_ack_q, host_ack_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_grant;
    logic              host_lost;

    // The stall cycle is the host issue cycle, so a stalled CPU always yields.
    assign host_grant = (state_q == ST_IDLE) && host_req && (!cpu_req || cpu_stall_q);
    assign host_lost  = (state_q == ST_IDLE) && host_req && !host_grant;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cpu_stall_q  <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else if (clocken) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cpu_stall_q  <= cpu_stall_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cpu_stall_d  = 1'b0;
        host_ack_d   = host_ack_q;
        host_rdata_d = host_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (host_grant) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end else if (host_lost) begin
                    if (cnt_q == MAX_STALL_C) begin
                        cpu_stall_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_CAPTURE: begin
                host_rdata_d = ram_q_b;
                host_ack_d   = 1'b1;
                state_d      = ST_ACK;
            end
            ST_ACK: begin
                if (!host_req) begin
                    host_ack_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ram_address_b = cpu_addr;
        ram_data_b    = cpu_wdata;
        ram_wren_b    = 2'b00;
        if (host_grant) begin
            ram_address_b = host_addr;
            ram_data_b    = host_wdata;
            ram_wren_b    = host_we ? host_be : 2'b00;
        end else if (cpu_req && !cpu_stall_q) begin
            ram_wren_b = cpu_wren;
        end
        if (!reset_n) begin
            ram_wren_b = 2'b00;
        end
    end

    assign ram_clocken = clocken;
    assign cpu_rdata   = ram_q_b;
    assign cpu_stall   = cpu_stall_q;
    assign host_ack    = host_ack_q;
    assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_j68_ram_port_arbiter.sv
// Directed bench for j68_ram_port_arbiter with a behavioural port-B RAM and a
// scoreboard of expected host read data.
module tb_j68_ram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clocken;
    logic        cpu_req;
    logic [1:0]  cpu_wren;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        host_req;
    logic        host_we;
    logic [1:0]  host_be;
    logic [10:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        ram_clocken;
    logic [1:0]  ram_wren_b;
    logic [10:0] ram_address_b;
    logic [15:0] ram_data_b;
    logic [15:0] ram_q_b = 16'h0000;

    bit [15:0]   mem [2048];
    bit [15:0]   ref_mem [2048];
    logic [15:0] exp_q [$];

    int checks   = 0;
    int failures = 0;

    j68_ram_port_arbiter #(
        .ADDR_W    (11),
        .DATA_W    (16),
        .MAX_STALL (3)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .clocken       (clocken),
        .cpu_req       (cpu_req),
        .cpu_wren      (cpu_wren),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .host_req      (host_req),
        .host_we       (host_we),
        .host_be       (host_be),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_ack      (host_ack),
        .host_rdata    (host_rdata),
        .ram_clocken   (ram_clocken),
        .ram_wren_b    (ram_wren_b),
        .ram_address_b (ram_address_b),
        .ram_data_b    (ram_data_b),
        .ram_q_b       (ram_q_b)
    );

    always #5 clock = ~clock;

    // Registered-output RAM, read-during-write returns old data.
    always @(posedge clock) begin
        if (ram_clocken) begin
            ram_q_b <= mem[ram_address_b];
            if (ram_wren_b[0]) mem[ram_address_b][7:0]  <= ram_data_b[7:0];
            if (ram_wren_b[1]) mem[ram_address_b][15:8] <= ram_data_b[15:8];
        end
    end

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_pop(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, 32'(host_rdata), 32'(e));
        end
    endtask

    // Uncontended host access: issue cycle checks, bounded wait for ack, data check.
    task automatic host_txn(input logic we, input logic [1:0] be, input logic [10:0] addr,
                            input logic [15:0] wd, input int exp_lat, input string tag);
        int lat;
        exp_q.push_back(ref_mem[addr]);
        if (we) ref_mem[addr] = merge(ref_mem[addr], wd, be);
        host_req = 1'b1; host_we = we; host_be = be; host_addr = addr; host_wdata = wd;
        #1;
        check({tag, "_issue_addr"}, 32'(ram_address_b), 32'(addr));
        check({tag, "_issue_wren"}, 32'(ram_wren_b), 32'(we ? be : 2'b00));
        lat = 0;
        while (host_ack !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_pop(tag);
        host_req = 1'b0;
        step();
        check({tag, "_ack_fall"}, 32'(host_ack), 32'd0);
    endtask

    // CPU requests every cycle; host read must wait for the forced stall (MAX_STALL=3).
    task automatic contended(input logic [10:0] haddr, input logic [10:0] caddr,
                             input string tag);
        cpu_req = 1'b1; cpu_wren = 2'b00; cpu_addr = caddr; cpu_wdata = 16'hFFFF;
        exp_q.push_back(ref_mem[haddr]);
        host_req = 1'b1; host_we = 1'b0; host_be = 2'b11; host_addr = haddr; host_wdata = 16'h0;
        for (int c = 0; c <= 6; c++) begin
            #1;
            check($sformatf("%s_stall_c%0d", tag, c), 32'(cpu_stall), 32'(c == 4));
            check($sformatf("%s_addr_c%0d", tag, c), 32'(ram_address_b),
                  32'((c == 4) ? haddr : caddr));
            check($sformatf("%s_ack_c%0d", tag, c), 32'(host_ack), 32'(c == 6));
            if (c == 1) check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(ref_mem[caddr]));
            if (c == 6) begin
                check_pop(tag);
                host_req = 1'b0;
            end
            step();
        end
        check({tag, "_ack_fall"}, 32'(host_ack), 32'd0);
        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; clocken = 1'b1;
        cpu_req = 1'b1; cpu_wren = 2'b11; cpu_addr = 11'h005; cpu_wdata = 16'hFFFF;
        host_req = 1'b1; host_we = 1'b1; host_be = 2'b11; host_addr = 11'h006;
        host_wdata = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_wren_%0d", i), 32'(ram_wren_b), 32'd0);
            check($sformatf("rst_ack_%0d", i), 32'(host_ack), 32'd0);
            check($sformatf("rst_stall_%0d", i), 32'(cpu_stall), 32'd0);
            check($sformatf("rst_rdata_%0d", i), 32'(host_rdata), 32'd0);
        end
        reset_n = 1'b1; cpu_req = 1'b0; cpu_wren = 2'b00; host_req = 1'b0; host_we = 1'b0;
        cpu_addr = 11'h7FF;
        step();
        check("rst_mem5", 32'(mem[5]), 32'd0);
        check("rst_mem6", 32'(mem[6]), 32'd0);

        host_txn(1'b1, 2'b11, 11'h005, 16'hC35A, 2, "pre5");
        host_txn(1'b1, 2'b11, 11'h123, 16'hBEEF, 2, "wr123");
        host_txn(1'b0, 2'b11, 11'h123, 16'h0000, 2, "rd123");

        contended(11'h005, 11'h123, "starve1");
        contended(11'h005, 11'h123, "starve2");

        // CPU and host rise together; CPU low-byte write lands first.
        cpu_req = 1'b1; cpu_wren = 2'b01; cpu_addr = 11'h005; cpu_wdata = 16'h00AA;
        ref_mem[5] = merge(ref_mem[5], 16'h00AA, 2'b01);
        exp_q.push_back(ref_mem[5]);
        host_req = 1'b1; host_we = 1'b0; host_be = 2'b11; host_addr = 11'h005;
        #1;
        check("prio_wren", 32'(ram_wren_b), 32'd1);
        check("prio_data", 32'(ram_data_b), 32'h00AA);
        check("prio_stall", 32'(cpu_stall), 32'd0);
        step();
        cpu_req = 1'b0; cpu_wren = 2'b00; cpu_addr = 11'h7FF;
        #1;
        check("prio_host_addr", 32'(ram_address_b), 32'h005);
        step();
        check("prio_ack_c2", 32'(host_ack), 32'd0);
        step();
        check("prio_ack_c3", 32'(host_ack), 32'd1);
        check_pop("prio");
        host_req = 1'b0;
        step();
        check("prio_ack_fall", 32'(host_ack), 32'd0);

        // Clock-enable gap during CAPTURE.
        exp_q.push_back(ref_mem[11'h123]);
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h123;
        step();
        clocken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("ce_ramce_%0d", i), 32'(ram_clocken), 32'd0);
            check($sformatf("ce_ack_%0d", i), 32'(host_ack), 32'd0);
            step();
        end
        clocken = 1'b1;
        #1;
        check("ce_ramce_on", 32'(ram_clocken), 32'd1);
        check("ce_ack_c5", 32'(host_ack), 32'd0);
        step();
        check("ce_ack_c6", 32'(host_ack), 32'd1);
        check_pop("ce");
        host_req = 1'b0;
        step();
        check("ce_ack_fall", 32'(host_ack), 32'd0);

        // Four-phase: request held after ack must not reissue the write.
        exp_q.push_back(ref_mem[11'h040]);
        ref_mem[11'h040] = merge(ref_mem[11'h040], 16'h1234, 2'b10);
        host_req = 1'b1; host_we = 1'b1; host_be = 2'b10; host_addr = 11'h040;
        host_wdata = 16'h1234;
        step();
        step();
        check("fp_ack", 32'(host_ack), 32'd1);
        check_pop("fp");
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            check($sformatf("fp_hold_ack_%0d", i), 32'(host_ack), 32'd1);
            check($sformatf("fp_hold_wren_%0d", i), 32'(ram_wren_b), 32'd0);
            check($sformatf("fp_hold_addr_%0d", i), 32'(ram_address_b), 32'h7FF);
        end
        host_req = 1'b0; host_we = 1'b0;
        step();
        check("fp_ack_fall", 32'(host_ack), 32'd0);
        host_txn(1'b0, 2'b11, 11'h040, 16'h0000, 2, "fp_rd");

        // Reset while acknowledging.
        exp_q.push_back(ref_mem[11'h123]);
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h123;
        step();
        step();
        check("mr_ack", 32'(host_ack), 32'd1);
        check_pop("mr");
        reset_n = 1'b0; host_req = 1'b0;
        step();
        check("mr_ack_rst", 32'(host_ack), 32'd0);
        check("mr_rdata_rst", 32'(host_rdata), 32'd0);
        reset_n = 1'b1;
        step();
        host_txn(1'b0, 2'b11, 11'h005, 16'h0000, 2, "mr_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/j68_ram_port_arbiter.md
# j68_ram_port_arbiter

Shares port B of the J68 2048x20 microcode/register block RAM between the CPU register-file path and a host debug/loader port. The CPU has fixed priority, and a bounded-starvation counter briefly stalls the CPU so that host accesses always complete. The block sits between the J68 core, the RAM's port B and the system debug bus. Port A (microcode fetch) is not touched.

## Interface
Parameters:
- ADDR_W, 11, RAM word address width
- DATA_W, 16, port B data width
- MAX_STALL, 7, number of host-losing cycles tolerated before the CPU is stalled (0..255)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- clocken  in  1  global clock enable
- cpu_req  in  1  CPU port-B access this cycle
- cpu_wren  in  2  CPU byte write enables ([1]=15:8, [0]=7:0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data (= ram_q_b)
- cpu_stall  out  1  CPU must hold its state this cycle; the CPU ANDs its own clock enable with !cpu_stall
- host_req  in  1  host request (four-phase)
- host_we  in  1  host write
- host_be  in  2  host byte enables
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  host acknowledge
- host_rdata  out  DATA_W  host read data, valid while host_ack=1
- ram_clocken  out  1  equals clocken
- ram_wren_b  out  2  RAM byte write enables
- ram_address_b  out  ADDR_W  RAM address
- ram_data_b  out  DATA_W  RAM write data
- ram_q_b  in  DATA_W  RAM registered read data (1-cycle latency, read-during-write returns old data)

## Operation
FSM states: IDLE, CAPTURE, ACK. There is a starvation counter `cnt` (8 bits).

Port-B mux (combinational, every cycle):
- Host granted: state=IDLE and host_req=1 and (cpu_req=0 or cpu_stall=1).
  - Drives host_addr and host_wdata.
  - ram_wren_b = host_we ? host_be : 0.
- Otherwise: drives cpu_addr, cpu_wdata and cpu_wren gated by cpu_req.
- When cpu_stall=1, cpu_req is ignored.
- When reset_n=0, ram_wren_b = 0.

FSM and counter (all updates only when clocken=1):
- IDLE, host granted → CAPTURE; cnt <= 0.
- IDLE, host_req=1 and host not granted (host lost the cycle):
  - if cnt == MAX_STALL: cpu_stall <= 1.
  - otherwise: cnt <= cnt+1.
- CAPTURE: host_rdata <= ram_q_b; host_ack <= 1; → ACK.
- ACK: hold host_ack=1 until host_req=0. On that cycle host_ack <= 0 → IDLE.
- cpu_stall is high for exactly one cycle, the host issue cycle. It is cleared the next cycle.

Further rules:
- Host writes also return host_rdata, which holds the pre-write data.
- host_addr, host_we, host_be and host_wdata must be stable from the host_req rise until host_ack.
- clocken=0: FSM, cnt, cpu_stall, host_ack and host_rdata all hold. The RAM also holds because ram_clocken=0.

## Timing
- Reset values: state IDLE, cnt 0, cpu_stall 0, host_ack 0, host_rdata 0.
- Reset mid-operation: returns to IDLE on the next edge and drops host_ack.
  - A host write issued before reset has completed.
  - A pending, unissued request is discarded.
- Uncontended host access (issue at cycle N): RAM sample at N, host_rdata/host_ack visible at N+2.
- Contended host access: the host loses MAX_STALL+1 cycles. cpu_stall is high on cycle MAX_STALL+1 counted from the first lost cycle, and the host issues on that cycle.
- CPU latency is unchanged: read data appears one cycle after cpu_req, except during a stall cycle.
- cpu_req and host_req simultaneous with cnt < MAX_STALL: CPU wins.
- New host_req while in ACK: no issue until the FSM returns to IDLE.

## Test plan
- Reset: hold reset_n=0 for 3 cycles while host_req=1 and cpu_req=1 with cpu_wren=2'b11 → ram_wren_b=0, host_ack=0, cpu_stall=0, RAM contents unchanged.
- Uncontended host write then read:
  - Write addr 0x123, data 0xBEEF, be=11, with cpu_req=0 → host_ack at N+2.
  - Read the same address → host_rdata=0xBEEF, ack at N+2.
- Starvation with MAX_STALL=3: cpu_req=1 constantly, host read issued at cycle 0 → cpu_stall=1 only at cycle 4, RAM address = host_addr at cycle 4, host_ack at cycle 6, cnt back to 0.
- CPU priority: cpu_req and host_req both rise at cycle 0, CPU writes 0x00AA to addr 5 with cpu_wren=01 → the CPU write lands at cycle 0. A later host read of addr 5 returns low byte 0xAA with the high byte unchanged.
- clocken gating: during host CAPTURE, drive clocken=0 for 4 cycles → host_ack is delayed by exactly 4 cycles, host_rdata is correct, ram_clocken=0 during the gap.
- Four-phase protocol: hold host_req high for 5 cycles after ack → host_ack stays 1 and no second issue occurs. Drop host_req → host_ack falls next cycle and the FSM returns to IDLE.
